uart_tx_param: RTL and testbench

//  Parametrised UART transmitter, successor to the fixed 8-bit/parity-always transmitter.

---
 rtl/uart_pkg.sv | 39 +++
 rtl/sync_fifo.sv | 86 ++++++++
 rtl/uart_tx_param.sv | 233 +++++++++++++++++++++++
 tb/tb_uart_tx_param.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package     : uart_pkg
// Description : Shared definitions for the parametrised UART transmitter.
//               Parity mode codes, FSM state encoding and a frame-length
//               helper that gives the number of clk cycles one frame takes.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Parity mode codes used for the PARITY parameter
    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Transmitter FSM state encoding
    typedef logic [2:0] tx_state_t;

    localparam tx_state_t ST_IDLE   = 3'd0;
    localparam tx_state_t ST_START  = 3'd1;
    localparam tx_state_t ST_DATA   = 3'd2;
    localparam tx_state_t ST_PARITY = 3'd3;
    localparam tx_state_t ST_STOP   = 3'd4;

    // Number of clk cycles in one complete frame (start, data, parity, stop)
    function automatic int frame_len(
        input int data_bits,
        input int parity,
        input int stop_bits,
        input int oversample,
        input int clk_div
    );
        int bits;
        bits = 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
        return bits * oversample * clk_div;
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO holding words queued for transmission.
//               Occupancy is tracked by a dedicated level counter rather than
//               derived from the pointers, so full and empty are unambiguous.
// Ports       : clk      - clock
//               rst      - asynchronous reset, active-high (flushes queue)
//               i_push   - write i_wdata (ignored when full)
//               i_pop    - drop head word (ignored when empty)
//               i_wdata  - word to write
//               o_rdata  - head word (valid when !o_empty)
//               o_full   - DEPTH words held
//               o_empty  - no words held
//               o_level  - words held, 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;
    localparam logic [c_LVL_W-1:0] c_LVL_FULL = c_LVL_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0] r_level;

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_level == c_LVL_FULL);
    assign w_empty   = (r_level == '0);
    assign w_do_push = i_push && !w_full;
    assign w_do_pop  = i_pop  && !w_empty;

    // Storage needs no reset: the pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_level = r_level;

endmodule : sync_fifo
`default_nettype wire

// File: rtl/uart_tx_param.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_param
// Description : Parametrised UART transmitter with valid/ready input and a
//               small TX FIFO. Frames are sent LSB first with optional
//               even/odd parity and one or two stop bits. Queued words go
//               out back-to-back: the stop bit is followed directly by the
//               next start bit. clk is the oversample clock, divided down by
//               an internal prescaler that only runs while a frame is active.
// Ports       : clk        - oversample clock
//               rst        - asynchronous reset, active-high
//               s_data     - word to send (DATA_BITS)
//               s_valid    - s_data valid
//               s_ready    - FIFO can accept; transfer on s_valid && s_ready
//               tx         - serial line, idle high (registered)
//               busy       - frame in progress or FIFO non-empty
//               fifo_level - entries held, 0..FIFO_DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = PARITY_NONE,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int CLK_DIV    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_OS_W  = $clog2(OVERSAMPLE);
    localparam int c_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_BIT_W = 4;
    localparam int c_LVL_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [c_OS_W-1:0]  c_OS_MAX     = c_OS_W'(OVERSAMPLE - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_MAX    = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_BIT_W-1:0] c_DATA_LAST  = c_BIT_W'(DATA_BITS - 1);
    localparam logic [c_BIT_W-1:0] c_STOP_LAST  = c_BIT_W'(STOP_BITS - 1);
    localparam logic               c_HAS_PARITY = (PARITY != PARITY_NONE);
    localparam logic               c_ODD_PARITY = (PARITY == PARITY_ODD);

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    tx_state_t              r_state;
    logic [c_DIV_W-1:0]     r_div;
    logic [c_OS_W-1:0]      r_os;
    logic [c_BIT_W-1:0]     r_bit;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par;
    logic                   r_tx;
    logic                   r_rdy_en;

    logic                   w_active;
    logic                   w_tick;
    logic                   w_bit_end;
    logic                   w_frame_end;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic [DATA_BITS-1:0]   w_rdata;
    logic                   w_par_calc;
    logic [c_LVL_W-1:0]     w_level;

    // ------------------------------------------------------------------------
    // Input handshake and queue
    // ------------------------------------------------------------------------
    // r_rdy_en keeps s_ready low throughout reset and rises on the first edge
    // after release; from then on s_ready simply mirrors !full. A pop in the
    // same cycle as full does not open the slot until the level has dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdy_en <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
        end
    end

    assign s_ready = r_rdy_en && !w_full;
    assign w_push  = s_valid && s_ready;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (s_data),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    // ------------------------------------------------------------------------
    // Bit timing: prescaler -> tick, tick counter -> bit end
    // ------------------------------------------------------------------------
    assign w_active    = (r_state != ST_IDLE);
    assign w_tick      = w_active && (r_div == c_DIV_MAX);
    assign w_bit_end   = w_tick && (r_os == c_OS_MAX);
    assign w_frame_end = (r_state == ST_STOP) && w_bit_end && (r_bit == c_STOP_LAST);

    // Both counters sit at zero while idle so every frame starts phase-aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= '0;
        end else if (!w_active || (r_div == c_DIV_MAX)) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_os <= '0;
        end else if (!w_active) begin
            r_os <= '0;
        end else if (w_tick) begin
            r_os <= (r_os == c_OS_MAX) ? '0 : r_os + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Frame sequencing
    // ------------------------------------------------------------------------
    // A word is taken from the FIFO either from IDLE or at the very end of the
    // last stop bit; the latter chains frames with no idle gap.
    assign w_pop = !w_empty && ((r_state == ST_IDLE) || w_frame_end);

    // Parity is captured from the popped word so later FIFO writes cannot
    // disturb the frame already in flight.
    assign w_par_calc = c_ODD_PARITY ? ~^w_rdata : ^w_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
        end else if (w_pop) begin
            r_state <= ST_START;
            r_bit   <= '0;
            r_shift <= w_rdata;
            r_par   <= w_par_calc;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_IDLE;
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_state <= ST_DATA;
                        r_bit   <= '0;
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        r_shift <= r_shift >> 1;
                        if (r_bit == c_DATA_LAST) begin
                            r_bit   <= '0;
                            r_state <= c_HAS_PARITY ? ST_PARITY : ST_STOP;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_bit_end) begin
                        r_state <= ST_STOP;
                        r_bit   <= '0;
                    end
                end
                ST_STOP: begin
                    // The pop branch above already covers a non-empty FIFO.
                    if (w_bit_end) begin
                        if (r_bit == c_STOP_LAST) begin
                            r_state <= ST_IDLE;
                            r_bit   <= '0;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_bit   <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Line driver
    // ------------------------------------------------------------------------
    // tx follows the state one cycle later; since every level is delayed by
    // the same cycle, bit widths are unaffected and there is no path from any
    // input to the pin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx <= 1'b1;
        end else begin
            case (r_state)
                ST_START:  r_tx <= 1'b0;
                ST_DATA:   r_tx <= r_shift[0];
                ST_PARITY: r_tx <= r_par;
                default:   r_tx <= 1'b1;
            endcase
        end
    end

    assign tx         = r_tx;
    assign busy       = w_active || (w_level != '0);
    assign fifo_level = w_level;

endmodule : uart_tx_param
`default_nettype wire

// File: tb/tb_uart_tx_param.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_uart_tx_param
// Description : Self-checking bench for uart_tx_param. Instance 0 uses the
//               default configuration and is watched by a scoreboard-driven
//               frame monitor; instances 1..3 cover even parity, odd parity
//               and 7 data bits / 2 stop bits / divide-by-3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_param;
    import uart_pkg::*;

    localparam int c_OS = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sd_v   [4];
    logic       sv_v   [4];
    logic       sr_v   [4];
    logic       tx_v   [4];
    logic       busy_v [4];
    logic [2:0] lvl_v  [4];

    int         n_total = 0;
    int         n_bad   = 0;
    int         cyc     = 0;
    logic [7:0] sb [$];
    int         start_t [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------------
    // Devices under test
    // ------------------------------------------------------------------------
    uart_tx_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16),
                    .CLK_DIV(1), .FIFO_DEPTH(4)) u_dut0 (
        .clk(clk), .rst(rst), .s_data(sd_v[0]), .s_valid(sv_v[0]), .s_ready(sr_v[0]),
        .tx(tx_v[0]), .busy(busy_v[0]), .fifo_level(lvl_v[0]));

    uart_tx_param #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .OVERSAMPLE(16),
                    .CLK_DIV(1), .FIFO_DEPTH(4)) u_dut1 (
        .clk(clk), .rst(rst), .s_data(sd_v[1]), .s_valid(sv_v[1]), .s_ready(sr_v[1]),
        .tx(tx_v[1]), .busy(busy_v[1]), .fifo_level(lvl_v[1]));

    uart_tx_param #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(16),
                    .CLK_DIV(1), .FIFO_DEPTH(4)) u_dut2 (
        .clk(clk), .rst(rst), .s_data(sd_v[2]), .s_valid(sv_v[2]), .s_ready(sr_v[2]),
        .tx(tx_v[2]), .busy(busy_v[2]), .fifo_level(lvl_v[2]));

    uart_tx_param #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .OVERSAMPLE(16),
                    .CLK_DIV(3), .FIFO_DEPTH(4)) u_dut3 (
        .clk(clk), .rst(rst), .s_data(sd_v[3][6:0]), .s_valid(sv_v[3]), .s_ready(sr_v[3]),
        .tx(tx_v[3]), .busy(busy_v[3]), .fifo_level(lvl_v[3]));

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    task automatic check_eq(input string tag, input int act, input int exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Offer one word, holding s_valid until accepted. waited = cycles stalled,
    // -1 on budget expiry.
    task automatic push(input int idx, input logic [7:0] w, input int budget, output int waited);
        waited = 0;
        @(negedge clk);
        sd_v[idx] = w;
        sv_v[idx] = 1'b1;
        while (sr_v[idx] !== 1'b1 && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        if (sr_v[idx] !== 1'b1) begin
            check_eq("push_timeout", 0, 1);
            sv_v[idx] = 1'b0;
            waited = -1;
            return;
        end
        @(posedge clk);
        if (idx == 0) sb.push_back(w);
        #1;
        sv_v[idx] = 1'b0;
    endtask

    // Count falling edges until tx is low; -1 on budget expiry.
    task automatic wait_fall(input int idx, input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx_v[idx] !== 1'b0 && n < budget);
        if (tx_v[idx] !== 1'b0) begin
            check_eq("fall_timeout", 0, 1);
            n = -1;
        end
    endtask

    task automatic wait_idle(input int idx, input int budget);
        int n;
        n = 0;
        while (busy_v[idx] !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy_v[idx] !== 1'b0) check_eq("idle_timeout", 0, 1);
    endtask

    // Compare tx against the ideal waveform for every clk of one frame,
    // starting at the falling edge where the start bit was first seen.
    task automatic watch_frame(input int idx, input logic [7:0] w, input int d, input int par,
                               input int stops, input int div,
                               output int nbad, output bit aborted, output int busy_end);
        int   bitlen;
        int   len;
        int   b;
        logic p;
        logic e;
        bitlen   = c_OS * div;
        len      = (1 + d + ((par != 0) ? 1 : 0) + stops) * bitlen;
        p        = 1'b0;
        for (int i = 0; i < d; i++) p = p ^ w[i];
        if (par == 2) p = ~p;
        nbad     = 0;
        aborted  = 1'b0;
        busy_end = -1;
        for (int t = 0; t < len; t++) begin
            if (t > 0) @(negedge clk);
            if (rst) begin
                aborted = 1'b1;
                return;
            end
            b = t / bitlen;
            if (b == 0)                         e = 1'b0;
            else if (b <= d)                    e = w[b-1];
            else if (par != 0 && b == d + 1)    e = p;
            else                                e = 1'b1;
            if (tx_v[idx] !== e) nbad++;
            busy_end = int'(busy_v[idx]);
        end
    endtask

    // Single-shot frame on one of the auxiliary instances.
    task automatic frame_test(input int idx, input logic [7:0] w, input int d, input int par,
                              input int stops, input int div, input string tag);
        int waited;
        int n;
        int nb;
        bit ab;
        int be;
        push(idx, w, 50, waited);
        wait_fall(idx, 20, n);
        check_eq({tag, "_latency"}, n, 3);
        if (n > 0) begin
            watch_frame(idx, w, d, par, stops, div, nb, ab, be);
            check_eq({tag, "_wave"}, nb, 0);
            check_eq({tag, "_idle_end"}, be, 0);
        end
    endtask

    // ------------------------------------------------------------------------
    // Scoreboard monitor for instance 0
    // ------------------------------------------------------------------------
    initial begin : mon0
        logic [7:0] exp_w;
        int         nb;
        bit         ab;
        int         be;
        forever begin
            @(negedge clk);
            if (!rst && tx_v[0] === 1'b0) begin
                start_t.push_back(cyc);
                if (sb.size() == 0) begin
                    check_eq("unexpected_frame", 1, 0);
                    repeat (frame_len(8, 0, 1, c_OS, 1) - 1) @(negedge clk);
                end else begin
                    exp_w = sb.pop_front();
                    watch_frame(0, exp_w, 8, 0, 1, 1, nb, ab, be);
                    if (!ab) begin
                        check_eq("a_wave", nb, 0);
                        check_eq("a_busy_end", be, (sb.size() != 0) ? 1 : 0);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin : main
        int         waited;
        int         n;
        int         total_wait;
        int         base;
        int         n0;
        int         flen;
        logic [7:0] words [8];

        for (int i = 0; i < 4; i++) begin
            sd_v[i] = '0;
            sv_v[i] = 1'b0;
        end
        words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        flen  = frame_len(8, 0, 1, c_OS, 1);

        // Reset state and release
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_tx", int'(tx_v[0]), 1);
        check_eq("rst_ready", int'(sr_v[0]), 0);
        check_eq("rst_busy", int'(busy_v[0]), 0);
        check_eq("rst_level", int'(lvl_v[0]), 0);
        rst = 1'b0;
        #1;
        check_eq("rel_ready_before_edge", int'(sr_v[0]), 0);
        @(negedge clk);
        check_eq("rel_ready_after_edge", int'(sr_v[0]), 1);

        // Single default frame 8'hA5
        push(0, 8'hA5, 50, waited);
        wait_fall(0, 20, n);
        check_eq("t1_latency", n, 3);
        wait_idle(0, 2 * flen);
        check_eq("t1_sb_empty", sb.size(), 0);
        check_eq("t1_frames", start_t.size(), 1);

        // Parity: 8'h07 has three ones -> even parity bit 1, odd parity bit 0
        frame_test(1, 8'h07, 8, 1, 1, 1, "t2_even");
        frame_test(2, 8'h07, 8, 2, 1, 1, "t2_odd");

        // 7 data bits, 2 stop bits, divide by 3
        frame_test(3, 8'h55, 7, 0, 2, 3, "t4_7n2");

        // Five back-to-back words: one in flight plus four queued
        base = start_t.size();
        total_wait = 0;
        for (int k = 0; k < 5; k++) begin
            push(0, words[k], 50, waited);
            total_wait += waited;
        end
        check_eq("t3_no_stall", total_wait, 0);
        @(negedge clk);
        check_eq("t3_level_full", int'(lvl_v[0]), 4);
        check_eq("t3_ready_low", int'(sr_v[0]), 0);

        // Source holds s_valid against a full FIFO; one accept per freed slot
        for (int k = 5; k < 8; k++) begin
            push(0, words[k], 4 * flen, waited);
            if (k == 5) check_eq("t6_held_50", (waited >= 50) ? 1 : 0, 1);
            @(negedge clk);
            check_eq("t6_level_after_accept", int'(lvl_v[0]), 4);
            check_eq("t6_ready_after_accept", int'(sr_v[0]), 0);
        end
        wait_idle(0, 10 * flen);
        check_eq("t6_sb_empty", sb.size(), 0);
        check_eq("t36_frames", start_t.size() - base, 8);
        // Default frame is (1+8+1)*16 = 160 clk; contiguous frames start 160 apart
        for (int i = base + 1; i < start_t.size(); i++) begin
            check_eq("t3_gap", start_t[i] - start_t[i-1], 160);
        end

        // Reset 70 clk into a frame with two words queued
        push(0, 8'hC3, 50, waited);
        push(0, 8'h3C, 50, waited);
        push(0, 8'h96, 50, waited);
        wait_fall(0, 20, n);
        repeat (70) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("t5_tx_async", int'(tx_v[0]), 1);
        check_eq("t5_level", int'(lvl_v[0]), 0);
        check_eq("t5_busy", int'(busy_v[0]), 0);
        check_eq("t5_ready", int'(sr_v[0]), 0);
        sb.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n0 = start_t.size();
        @(negedge clk);
        check_eq("t5_ready_release", int'(sr_v[0]), 1);
        repeat (400) @(negedge clk);
        check_eq("t5_quiet_frames", start_t.size() - n0, 0);
        check_eq("t5_quiet_busy", int'(busy_v[0]), 0);
        push(0, 8'h5A, 50, waited);
        wait_fall(0, 20, n);
        check_eq("t5_new_latency", n, 3);
        wait_idle(0, 2 * flen);
        check_eq("t5_new_frames", start_t.size() - n0, 1);
        check_eq("t5_sb_empty", sb.size(), 0);

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_uart_tx_param
`default_nettype wire
